score_argmax_unit: RTL and testbench

- Sequential classification stage directly downstream of the MNIST network top.
- On the network `done` pulse it captures the packed 10×16-bit signed Q8.8 score bus and scans it one class per cycle.
- Produces the winning class index, its score, the margin over the runner-up and a low-confidence flag.
- The result is presented through a valid/ready handshake to the consumer (display, UART reporter or bench).

---
 rtl/score_argmax_if.sv | 28 ++
 rtl/score_argmax_unit.sv | 110 +++++++++++
 tb/tb_score_argmax_unit.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/score_argmax_if.sv
// Handshake/result bundle between the MNIST network top, the argmax stage and its consumer.
// The DUT uses the slave modport; the producer/consumer side uses master.
interface score_argmax_if #(
    parameter int NUM_CLASSES = 10,
    parameter int SCORE_W     = 16,
    parameter int IDX_W       = 4
);
    logic [NUM_CLASSES*SCORE_W-1:0] scores_in;
    logic                           in_valid;
    logic                           busy;
    logic                           result_valid;
    logic                           result_ready;
    logic [IDX_W-1:0]               class_idx;
    logic [SCORE_W-1:0]             max_score;
    logic [SCORE_W-1:0]             margin;
    logic                           low_conf;
    logic                           overrun;

    modport master (
        output scores_in, in_valid, result_ready,
        input  busy, result_valid, class_idx, max_score, margin, low_conf, overrun
    );

    modport slave (
        input  scores_in, in_valid, result_ready,
        output busy, result_valid, class_idx, max_score, margin, low_conf, overrun
    );
endinterface

// File: rtl/score_argmax_unit.sv
// Sequential argmax over the packed Q8.8 class scores: one class per cycle, then holds
// index, max, margin over runner-up and a low-confidence flag until the consumer accepts.
module score_argmax_unit #(
    parameter int                 NUM_CLASSES   = 10,
    parameter int                 SCORE_W       = 16,
    parameter int                 IDX_W         = 4,
    parameter logic [SCORE_W-1:0] MARGIN_THRESH = 16'h0100
) (
    input  logic         clk,
    input  logic         rst,
    score_argmax_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic signed [SCORE_W-1:0] SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};
    localparam logic [IDX_W-1:0]          LAST_IDX  = IDX_W'(NUM_CLASSES - 1);

    logic [1:0]                            state;
    logic [NUM_CLASSES-1:0][SCORE_W-1:0]   cap_q;
    logic [IDX_W-1:0]                      idx_q;
    logic [IDX_W-1:0]                      best_idx_q;
    logic signed [SCORE_W-1:0]             best_q;
    logic signed [SCORE_W-1:0]             second_q;

    logic signed [SCORE_W-1:0]             s;
    logic signed [SCORE_W-1:0]             nxt_best;
    logic signed [SCORE_W-1:0]             nxt_second;
    logic [IDX_W-1:0]                      nxt_best_idx;
    logic [SCORE_W:0]                      diff;
    logic [SCORE_W-1:0]                    nxt_margin;

    assign s = $signed(cap_q[idx_q]);

    // Running max / runner-up update; strict compares keep the lowest index on ties.
    always_comb begin
        nxt_best     = best_q;
        nxt_second   = second_q;
        nxt_best_idx = best_idx_q;
        if (idx_q == '0) begin
            nxt_best     = s;
            nxt_best_idx = '0;
            nxt_second   = SCORE_MIN;
        end else if (s > best_q) begin
            nxt_second   = best_q;
            nxt_best     = s;
            nxt_best_idx = idx_q;
        end else if (s > second_q) begin
            nxt_second   = s;
        end
    end

    // One extra bit so max - MIN cannot overflow; the low SCORE_W bits are the unsigned margin.
    assign diff       = {nxt_best[SCORE_W-1], nxt_best} - {nxt_second[SCORE_W-1], nxt_second};
    assign nxt_margin = diff[SCORE_W-1:0];

    assign bus.busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            cap_q            <= '0;
            idx_q            <= '0;
            best_idx_q       <= '0;
            best_q           <= '0;
            second_q         <= SCORE_MIN;
            bus.result_valid <= 1'b0;
            bus.class_idx    <= '0;
            bus.max_score    <= '0;
            bus.margin       <= '0;
            bus.low_conf     <= 1'b0;
            bus.overrun      <= 1'b0;
        end else begin
            if (bus.in_valid && state != S_IDLE)
                bus.overrun <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        cap_q <= bus.scores_in;
                        idx_q <= '0;
                        state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    best_q     <= nxt_best;
                    second_q   <= nxt_second;
                    best_idx_q <= nxt_best_idx;
                    if (idx_q == LAST_IDX) begin
                        bus.class_idx    <= nxt_best_idx;
                        bus.max_score    <= nxt_best;
                        bus.margin       <= nxt_margin;
                        bus.low_conf     <= (nxt_margin < MARGIN_THRESH);
                        bus.result_valid <= 1'b1;
                        state            <= S_HOLD;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (bus.result_valid && bus.result_ready) begin
                        bus.result_valid <= 1'b0;
                        state            <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_score_argmax_unit.sv
// Directed bench for score_argmax_unit: stimulus pushes hand-computed results into a queue,
// an independent monitor pops and compares on each new result_valid and checks hold stability.
module tb_score_argmax_unit;
    localparam int NC = 10;
    localparam int W  = 16;
    localparam int IW = 4;

    typedef struct {
        logic [IW-1:0] idx;
        logic [W-1:0]  mx;
        logic [W-1:0]  mg;
        logic          lc;
        int            rise;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    score_argmax_if #(.NUM_CLASSES(NC), .SCORE_W(W), .IDX_W(IW)) bus ();

    score_argmax_unit #(.NUM_CLASSES(NC), .SCORE_W(W), .IDX_W(IW), .MARGIN_THRESH(16'h0100)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t q[$];
    exp_t cur;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    logic rv_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: new result -> pop and compare; held result -> must not move.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                rv_prev = 1'b0;
            end else begin
                if (bus.result_valid && !rv_prev) begin
                    if (q.size() == 0) begin
                        chk("unexpected_result", 64'd1, 64'd0);
                    end else begin
                        cur = q.pop_front();
                        chk("latency",   64'(cyc),           64'(cur.rise));
                        chk("class_idx", 64'(bus.class_idx), 64'(cur.idx));
                        chk("max_score", 64'(bus.max_score), 64'(cur.mx));
                        chk("margin",    64'(bus.margin),    64'(cur.mg));
                        chk("low_conf",  64'(bus.low_conf),  64'(cur.lc));
                    end
                end else if (bus.result_valid) begin
                    chk("hold_stable", 64'({bus.class_idx, bus.max_score, bus.margin, bus.low_conf}),
                        64'({cur.idx, cur.mx, cur.mg, cur.lc}));
                end
                rv_prev = bus.result_valid;
            end
        end
    end

    function automatic logic [NC*W-1:0] fill(input logic [W-1:0] v);
        logic [NC*W-1:0] r;
        for (int k = 0; k < NC; k++) r[k*W +: W] = v;
        return r;
    endfunction

    // Called at a negedge: pulse in_valid for one cycle, then scramble scores_in.
    task automatic issue(input logic [NC*W-1:0] sc, input bit push, input logic [IW-1:0] ei,
                         input logic [W-1:0] em, input logic [W-1:0] eg, input logic el);
        exp_t e;
        bus.scores_in = sc;
        bus.in_valid  = 1'b1;
        if (push) begin
            e = '{ei, em, eg, el, cyc + NC + 1};
            q.push_back(e);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.scores_in = {$urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!bus.busy && !bus.result_valid && q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("idle_timeout", 64'(ok), 64'd1);
    endtask

    task automatic wait_rv();
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.result_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("rv_timeout", 64'(ok), 64'd1);
    endtask

    logic [NC*W-1:0] v;

    initial begin
        bus.scores_in    = '0;
        bus.in_valid     = 1'b0;
        bus.result_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy",      64'(bus.busy),         64'd0);
        chk("rst_rv",        64'(bus.result_valid), 64'd0);
        chk("rst_class_idx", 64'(bus.class_idx),    64'd0);
        chk("rst_max_score", 64'(bus.max_score),    64'd0);
        chk("rst_margin",    64'(bus.margin),       64'd0);
        chk("rst_low_conf",  64'(bus.low_conf),     64'd0);
        chk("rst_overrun",   64'(bus.overrun),      64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic: k*0x10, class 7 = 0x0500; runner-up is class 9 = 0x0090.
        for (int k = 0; k < NC; k++) v[k*W +: W] = 16'(k * 16);
        v[7*W +: W] = 16'h0500;
        issue(v, 1, 4'd7, 16'h0500, 16'h0470, 1'b0);
        wait_idle();

        // All -1.0: lowest index wins, zero margin.
        issue(fill(16'hFF00), 1, 4'd0, 16'hFF00, 16'h0000, 1'b1);
        wait_idle();

        // Full-range margin.
        v = fill(16'h8000);
        v[3*W +: W] = 16'h7FFF;
        issue(v, 1, 4'd3, 16'h7FFF, 16'hFFFF, 1'b0);
        wait_idle();
        chk("overrun_clean", 64'(bus.overrun), 64'd0);

        // Backpressure with a dropped pulse during HOLD.
        bus.result_ready = 1'b0;
        v = fill(16'h0000);
        v[5*W +: W] = 16'h0180;
        v[2*W +: W] = 16'h0100;
        issue(v, 1, 4'd5, 16'h0180, 16'h0080, 1'b1);
        wait_rv();
        repeat (5) @(negedge clk);
        issue(fill(16'h7000), 0, '0, '0, '0, 1'b0);
        chk("overrun_hold", 64'(bus.overrun), 64'd1);
        repeat (14) @(negedge clk);
        chk("rv_held", 64'(bus.result_valid), 64'd1);
        bus.result_ready = 1'b1;
        @(negedge clk);
        chk("rv_release",   64'(bus.result_valid), 64'd0);
        chk("busy_release", 64'(bus.busy),         64'd0);

        // Mid-scan reset in cycle 5 aborts; overrun clears.
        issue(fill(16'h0400), 0, '0, '0, '0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy",    64'(bus.busy),         64'd0);
        chk("abort_rv",      64'(bus.result_valid), 64'd0);
        chk("abort_outputs", 64'({bus.class_idx, bus.max_score, bus.margin, bus.low_conf}), 64'd0);
        chk("abort_overrun", 64'(bus.overrun),      64'd0);
        rst = 1'b0;
        v = fill(16'hF000);
        v[1*W +: W] = 16'h0123;
        issue(v, 1, 4'd1, 16'h0123, 16'h1123, 1'b0);
        wait_idle();

        // Back-to-back at the minimum 12-cycle gap; margin exactly at threshold, then a tie.
        v = fill(16'hFE00);
        v[0*W +: W] = 16'h0200;
        v[9*W +: W] = 16'h0100;
        issue(v, 1, 4'd0, 16'h0200, 16'h0100, 1'b0);
        repeat (11) @(negedge clk);
        v = fill(16'h0000);
        v[8*W +: W] = 16'h0050;
        v[9*W +: W] = 16'h0050;
        issue(v, 1, 4'd8, 16'h0050, 16'h0000, 1'b1);
        repeat (4) @(negedge clk);
        chk("overrun_b2b", 64'(bus.overrun), 64'd0);
        issue(fill(16'h1234), 0, '0, '0, '0, 1'b0);
        chk("overrun_third", 64'(bus.overrun), 64'd1);
        wait_idle();
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
